// File: rtl/twiddle_gen.sv
// Twiddle-factor generator and phase sequencer for one radix-2 SDF FFT stage.
// Optional conjugate output for IFFT use is enabled with the TWIDDLE_INVERSE_EN macro.
module twiddle_gen #(
  parameter int N    = 64,
  parameter int W    = 24,
  parameter int FRAC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
`ifdef TWIDDLE_INVERSE_EN
  input  logic                inv,
`endif
  output logic signed [W-1:0] w_r,
  output logic signed [W-1:0] w_i,
  output logic [1:0]          state,
  output logic                out_valid,
  output logic                last
);

  localparam int KW = $clog2(N) - 1;
  localparam int Q  = N / 4;
  localparam logic [KW-1:0]       Q_K    = KW'(Q);
  localparam logic [KW-1:0]       K_LAST = KW'(N / 2 - 1);
  localparam logic signed [W-1:0] UNITY  = W'(2 ** FRAC);
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    PH_FILL = 2'd0,
    PH_BFLY = 2'd1,
    PH_MULT = 2'd2
  } phase_e;

  function automatic int round_away(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    else          return -int'($floor(-x + 0.5));
  endfunction

  function automatic int cos_entry(input int m);
    real a;
    a = 2.0 * PI * real'(m) / real'(N);
    return round_away((2.0 ** FRAC) * $cos(a));
  endfunction

  // Quarter-wave cosine table, entries 0..N/4 inclusive.
  logic signed [W-1:0] ctab [0:Q];
  for (genvar m = 0; m <= Q; m++) begin : g_tab
    localparam int CV = cos_entry(m);
    assign ctab[m] = W'(CV);
  end

  logic          fill_q, fill_d;
  logic          phase_q, phase_d;
  logic [KW-1:0] cnt_q, cnt_d;
  phase_e        cur_ph;

  always_comb begin
    fill_d  = fill_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    cur_ph  = fill_q ? PH_FILL : (phase_q ? PH_MULT : PH_BFLY);
    if (in_valid) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == K_LAST) begin
        fill_d = 1'b0;
        // Leaving FILL always enters BUTTERFLY; afterwards the halves alternate.
        if (!fill_q) phase_d = ~phase_q;
      end
    end
  end

  logic                upper;
  logic [KW-1:0]       idx_r, idx_i;
  logic signed [W-1:0] tw_r, tw_i;

  always_comb begin
    upper = (cnt_q > Q_K);
    // N/2 - k taken modulo 2^KW, which equals N/2 - k for k > N/4.
    idx_r = upper ? (KW'(0) - cnt_q) : cnt_q;
    idx_i = upper ? (cnt_q - Q_K) : (Q_K - cnt_q);
    tw_r  = upper ? -ctab[idx_r] : ctab[idx_r];
`ifdef TWIDDLE_INVERSE_EN
    tw_i  = inv ? ctab[idx_i] : -ctab[idx_i];
`else
    tw_i  = -ctab[idx_i];
`endif
    if (cur_ph != PH_MULT) begin
      tw_r = UNITY;
      tw_i = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q    <= 1'b1;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      state     <= PH_FILL;
      w_r       <= UNITY;
      w_i       <= '0;
    end else begin
      fill_q    <= fill_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      out_valid <= in_valid;
      if (in_valid) begin
        state <= cur_ph;
        w_r   <= tw_r;
        w_i   <= tw_i;
        last  <= (cur_ph == PH_MULT) && (cnt_q == K_LAST);
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen: N=64/FRAC=8 main instance plus an N=16/FRAC=14 instance.
module tb_twiddle_gen;

  localparam int N = 64, W = 24, FRAC = 8;
  localparam int W16 = 18;

  logic clk = 1'b0;
  logic rst, in_valid;
  logic signed [W-1:0]   w_r, w_i;
  logic [1:0]            state;
  logic                  out_valid, last;
  logic signed [W16-1:0] w_r16, w_i16;
  logic [1:0]            state16;
  logic                  out_valid16, last16;

  twiddle_gen #(.N(N), .W(W), .FRAC(FRAC)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .w_r(w_r), .w_i(w_i), .state(state), .out_valid(out_valid), .last(last)
  );

  twiddle_gen #(.N(16), .W(W16), .FRAC(14)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .w_r(w_r16), .w_i(w_i16), .state(state16), .out_valid(out_valid16), .last(last16)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, lst, wr, wi, k;
    bit known;
    int st16, lst16, wr16, wi16;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_acc;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ph(input int n, input int h);
    if (n < h) return 0;
    return (((n - h) / h) % 2 == 0) ? 1 : 2;
  endfunction

  function automatic exp_t model(input int n);
    exp_t e;
    int wr16t[8];
    int wi16t[8];
    int k16;
    wr16t = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
    wi16t = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};
    e.st = ph(n, 32);
    e.k = n % 32;
    e.lst = (e.st == 2 && e.k == 31) ? 1 : 0;
    e.known = 1'b1;
    e.wr = 256;
    e.wi = 0;
    if (e.st == 2) begin
      case (e.k)
        0:  begin e.wr = 256;  e.wi = 0;    end
        1:  begin e.wr = 255;  e.wi = -25;  end
        4:  begin e.wr = 237;  e.wi = -98;  end
        8:  begin e.wr = 181;  e.wi = -181; end
        16: begin e.wr = 0;    e.wi = -256; end
        20: begin e.wr = -98;  e.wi = -237; end
        24: begin e.wr = -181; e.wi = -181; end
        31: begin e.wr = -255; e.wi = -25;  end
        default: e.known = 1'b0;
      endcase
    end
    e.st16 = ph(n, 8);
    k16 = n % 8;
    e.lst16 = (e.st16 == 2 && k16 == 7) ? 1 : 0;
    e.wr16 = (e.st16 == 2) ? wr16t[k16] : 16384;
    e.wi16 = (e.st16 == 2) ? wi16t[k16] : 0;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.st = 0; e.lst = 0; e.wr = 256; e.wi = 0; e.k = 0; e.known = 1'b1;
    e.st16 = 0; e.lst16 = 0; e.wr16 = 16384; e.wi16 = 0;
    return e;
  endfunction

  task automatic check_outputs(input bit v);
    check("out_valid", out_valid, v);
    check("state", state, cur.st);
    check("last", last, cur.lst);
    if (cur.known) begin
      check("w_r", w_r, cur.wr);
      check("w_i", w_i, cur.wi);
    end
    if (v && cur.st == 2 && cur.k == 1) check("w_i_bits", {1'b0, w_i}, 24'hFFFFE7);
    check("out_valid16", out_valid16, v);
    check("state16", state16, cur.st16);
    check("last16", last16, cur.lst16);
    check("w_r16", w_r16, cur.wr16);
    check("w_i16", w_i16, cur.wi16);
  endtask

  task automatic drive(input bit v);
    in_valid = v;
    if (v) begin
      exp_q.push_back(model(n_acc));
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (v) cur = exp_q.pop_front();
    check_outputs(v);
  endtask

  task automatic do_reset(input bit v, input int cycles);
    rst = 1'b1;
    in_valid = v;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    n_acc = 0;
    exp_q.delete();
    cur = reset_exp();
    check_outputs(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    n_acc = 0;
    cur = reset_exp();

    do_reset(1'b0, 2);
    repeat (160) drive(1'b1);

    // Gapped traffic, then reset on the cycle that would carry MULTIPLY k=10.
    do_reset(1'b0, 1);
    for (int i = 0; i < 37; i++) begin
      drive(1'b1);
      drive(1'b0);
      drive(1'b0);
      drive(1'b1);
    end
    do_reset(1'b1, 1);
    repeat (33) drive(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
